// File: rtl/jk_excitation_sequencer.sv
// Drives J/K into an external JK flop so its Q follows a queued stream of
// target bits. After each step it checks Q and keeps a saturating mismatch count.
module jk_excitation_sequencer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             EN,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic             IN_BIT,
    input  logic             Q_FB,
    input  logic             CLR_ERR,
    output logic             J,
    output logic             K,
    output logic             CHK_VALID,
    output logic             CHK_ERR,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic             IDLE
);
    localparam int               AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]      FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]      CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [CNT_W-1:0] ERR_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ERR_MAX  = '1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;

    logic             mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [1:0]       state_q, state_d;
    logic             tgt_q, tgt_d;
    logic             j_q, j_d;
    logic             k_q, k_d;
    logic             chk_valid_q, chk_valid_d;
    logic             chk_err_q, chk_err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic push;
    logic pop;
    logic can_pop;
    logic head_bit;
    logic ex_j;
    logic ex_k;
    logic mismatch;

    assign IN_READY = (count_q != FULL_CNT);
    assign push     = IN_VALID && IN_READY;
    assign can_pop  = EN && (count_q != '0);
    assign head_bit = mem_q[rd_ptr_q];

    // J only sets a 0, K only clears a 1; the toggle code is never produced.
    assign ex_j     = head_bit & ~Q_FB;
    assign ex_k     = ~head_bit & Q_FB;
    assign mismatch = (Q_FB != tgt_q);

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= IN_BIT;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        j_d         = 1'b0;
        k_d         = 1'b0;
        chk_valid_d = 1'b0;
        chk_err_d   = chk_err_q;
        err_cnt_d   = err_cnt_q;
        pop         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (can_pop) begin
                    pop     = 1'b1;
                    tgt_d   = head_bit;
                    j_d     = ex_j;
                    k_d     = ex_k;
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                chk_valid_d = 1'b1;
                chk_err_d   = mismatch;
                if (mismatch && (err_cnt_q != ERR_MAX)) begin
                    err_cnt_d = err_cnt_q + ERR_ONE;
                end
                // Back-to-back steps reload J/K here, giving one bit per two cycles.
                if (can_pop) begin
                    pop     = 1'b1;
                    tgt_d   = head_bit;
                    j_d     = ex_j;
                    k_d     = ex_k;
                    state_d = S_DRIVE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (CLR_ERR) begin
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= S_IDLE;
            tgt_q       <= 1'b0;
            j_q         <= 1'b0;
            k_q         <= 1'b0;
            chk_valid_q <= 1'b0;
            chk_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            j_q         <= j_d;
            k_q         <= k_d;
            chk_valid_q <= chk_valid_d;
            chk_err_q   <= chk_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign J         = j_q;
    assign K         = k_q;
    assign CHK_VALID = chk_valid_q;
    assign CHK_ERR   = chk_err_q;
    assign ERR_CNT   = err_cnt_q;
    assign IDLE      = (state_q == S_IDLE) && (count_q == '0);

endmodule
